arb_burst_lock_mux: RTL and testbench
=====================================

ARB_BURST_LOCK_MUX -- requirements
Module: arb_burst_lock_mux

Interface
REQ-001 SHALL have parameter REQ_NUM, default 4: number of requesting source ports (2..16).
REQ-002 SHALL have parameter DATA_W, default 32: payload width per beat.
REQ-003 SHALL have parameter TIMEOUT, default 16: stall limit in cycles, used only with ARB_LOCK_MUX_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports s_valid / s_last  input  REQ_NUM each  per-source beat valid / last beat of burst.
REQ-007 SHALL have port s_data  input  REQ_NUM*DATA_W  per-source payload; source i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port s_ready  output  REQ_NUM  per-source beat accept.
REQ-009 SHALL have port arb_req  output  REQ_NUM  request vector to the external round-robin arbiter.
REQ-010 SHALL have port arb_en  output  1  one-cycle pulse that advances the arbiter's priority pointer.
REQ-011 SHALL have port arb_grant  input  REQ_NUM  combinational grant returned by the arbiter.
REQ-012 SHALL have ports m_valid / m_last  output  1 each, m_data  output  DATA_W, m_ready  input  1: merged downstream stream.
REQ-013 SHALL have port m_src  output  $clog2(REQ_NUM)  binary index of the locked source.
REQ-014 SHALL have port busy  output  1  high while a source is locked; port lock_err  output  1  timeout release pulse.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and LOCK.
REQ-016 In IDLE: arb_req = s_valid; s_ready = 0; m_valid = 0.
REQ-017 In LOCK: arb_req = 0; arb_en = 0.
REQ-018 IDLE->LOCK when |s_valid and |arb_grant: register lock_oh <= lowest set bit of arb_grant, drive arb_en = 1 in that same cycle.
REQ-019 If |s_valid but arb_grant == 0: stay IDLE, arb_en = 0.
REQ-020 If arb_grant is not one-hot: lock only its lowest set bit.
REQ-021 If arb_grant has bits outside s_valid: still lock; no error raised.
REQ-022 In LOCK: m_valid = |(s_valid & lock_oh); m_data/m_last = selected source's fields; s_ready = lock_oh & {REQ_NUM{m_ready}}.
REQ-023 Non-locked sources SHALL see s_ready = 0 throughout LOCK.
REQ-024 LOCK->IDLE on the cycle m_valid & m_ready & m_last; next arbitration in the following IDLE cycle.
REQ-025 Resulting min cost per burst: 1 arbitration cycle + N beats; a 1-beat burst takes 2 cycles.
REQ-026 Combinational path m_ready -> s_ready and s_valid -> m_valid SHALL exist; no data register in the datapath.
REQ-027 busy = (state == LOCK); m_src = encoded lock_oh, held until the next lock.
REQ-028 Locked source deasserting s_valid mid-burst: stay in LOCK with m_valid = 0 (no timeout when the macro is undefined).

Reset
REQ-029 On rstn low, asynchronously: state = IDLE, lock_oh = 0, m_src = 0, timeout counter = 0, lock_err = 0.
REQ-030 Reset mid-burst SHALL abandon the burst; no beat is accepted in the cycle rstn is low.
REQ-031 All outputs SHALL be 0 during reset, except arb_req, which follows s_valid.

Configuration
REQ-032 Macro ARB_LOCK_MUX_TIMEOUT_EN defined: a counter increments each LOCK cycle with m_valid = 0 and clears on any accepted beat.
REQ-033 With the macro defined, when the counter reaches TIMEOUT-1: return to IDLE and pulse lock_err for one cycle.
REQ-034 Macro undefined: no counter exists, lock_err is tied to 0, and LOCK exits only per REQ-024.

Verification
REQ-035 Reset, then s_valid=4'b0101, arb_grant=4'b0001 -> arb_en pulse 1 cycle, busy=1 next cycle, m_src=0, s_ready[2]=0.
REQ-036 Source 1 sends a 4-beat burst, m_ready toggling 1,0,1,1,1 -> exactly 4 beats pass in order, with a return to IDLE after the beat whose m_last=1.
REQ-037 arb_grant=4'b0110 while s_valid=4'b0110 -> source 1 locked, m_src=1.
REQ-038 arb_grant=0 while s_valid=4'b1000 for 5 cycles -> stays IDLE, arb_en=0, busy=0.
REQ-039 rstn pulsed low at beat 2 of 4 -> outputs zero immediately; after release, fresh arbitration with arb_en pulse.
REQ-040 With ARB_LOCK_MUX_TIMEOUT_EN and TIMEOUT=16, the locked source drops s_valid for 16 cycles -> lock_err=1 for one cycle, then IDLE.

Source files
------------

// File: rtl/arb_burst_lock_mux.sv
// Burst-lock multiplexer: an external round-robin arbiter picks a source, which then owns
// the merged output until its last beat. Optional stall watchdog: define ARB_LOCK_MUX_TIMEOUT_EN.
module arb_burst_lock_mux #(
    parameter int REQ_NUM = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [REQ_NUM-1:0]        s_valid,
    input  logic [REQ_NUM-1:0]        s_last,
    input  logic [REQ_NUM*DATA_W-1:0] s_data,
    output logic [REQ_NUM-1:0]        s_ready,
    output logic [REQ_NUM-1:0]        arb_req,
    output logic                      arb_en,
    input  logic [REQ_NUM-1:0]        arb_grant,
    output logic                      m_valid,
    output logic                      m_last,
    output logic [DATA_W-1:0]         m_data,
    input  logic                      m_ready,
    output logic [$clog2(REQ_NUM)-1:0] m_src,
    output logic                      busy,
    output logic                      lock_err
);

    localparam int SRC_W = $clog2(REQ_NUM);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [REQ_NUM-1:0] lock_oh_q, lock_oh_d;
    logic [SRC_W-1:0]   m_src_q, m_src_d;
    logic [REQ_NUM-1:0] grant_oh_s;
    logic               is_lock_s;
    logic               sel_valid_s;
    logic               sel_last_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               beat_acc_s;

    // A grant that is not one-hot is reduced to its lowest set bit.
    function automatic logic [REQ_NUM-1:0] lowest_oh(input logic [REQ_NUM-1:0] vec);
        logic [REQ_NUM-1:0] oh;
        logic               found;
        oh    = {REQ_NUM{1'b0}};
        found = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (vec[i] && !found) begin
                oh[i] = 1'b1;
                found = 1'b1;
            end else begin
                oh[i] = oh[i];
            end
        end
        return oh;
    endfunction

    function automatic logic [SRC_W-1:0] encode_oh(input logic [REQ_NUM-1:0] oh);
        logic [SRC_W-1:0] idx;
        idx = {SRC_W{1'b0}};
        for (int i = 0; i < REQ_NUM; i++) begin
            if (oh[i]) begin
                idx = SRC_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign grant_oh_s = lowest_oh(arb_grant);
    assign is_lock_s  = (state_q == ST_LOCK);

    // AND-OR select of the locked source's beat fields
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = {DATA_W{1'b0}};
        for (int i = 0; i < REQ_NUM; i++) begin
            sel_valid_s = sel_valid_s | (s_valid[i] & lock_oh_q[i]);
            sel_last_s  = sel_last_s  | (s_last[i]  & lock_oh_q[i]);
            sel_data_s  = sel_data_s  | (s_data[i*DATA_W +: DATA_W] & {DATA_W{lock_oh_q[i]}});
        end
    end

    // The datapath is deliberately flop-free: ready and valid pass straight through.
    assign m_valid    = is_lock_s & sel_valid_s;
    assign m_last     = is_lock_s & sel_last_s;
    assign m_data     = is_lock_s ? sel_data_s : {DATA_W{1'b0}};
    assign s_ready    = is_lock_s ? (lock_oh_q & {REQ_NUM{m_ready}}) : {REQ_NUM{1'b0}};
    assign arb_req    = is_lock_s ? {REQ_NUM{1'b0}} : s_valid;
    assign arb_en     = rstn & ~is_lock_s & (|s_valid) & (|arb_grant);
    assign busy       = is_lock_s;
    assign m_src      = m_src_q;
    assign beat_acc_s = m_valid & m_ready;

`ifdef ARB_LOCK_MUX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_err_q, lock_err_d;

    assign lock_err = lock_err_q;
`else
    logic unused_timeout_s;

    assign unused_timeout_s = ^32'(TIMEOUT);
    assign lock_err         = 1'b0;
`endif

    // Next-state: arbitrate in IDLE, hold the lock until the last beat (or a stall timeout)
    always_comb begin
        state_d   = state_q;
        lock_oh_d = lock_oh_q;
        m_src_d   = m_src_q;
`ifdef ARB_LOCK_MUX_TIMEOUT_EN
        cnt_d      = cnt_q;
        lock_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef ARB_LOCK_MUX_TIMEOUT_EN
                cnt_d = {CNT_W{1'b0}};
`endif
                if ((|s_valid) && (|arb_grant)) begin
                    state_d   = ST_LOCK;
                    lock_oh_d = grant_oh_s;
                    m_src_d   = encode_oh(grant_oh_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
`ifdef ARB_LOCK_MUX_TIMEOUT_EN
                if (beat_acc_s && m_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (beat_acc_s) begin
                    cnt_d = {CNT_W{1'b0}};
                end else if (!m_valid) begin
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d    = ST_IDLE;
                        lock_err_d = 1'b1;
                        cnt_d      = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
`else
                if (beat_acc_s && m_last) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCK;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and lock registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            lock_oh_q <= {REQ_NUM{1'b0}};
            m_src_q   <= {SRC_W{1'b0}};
`ifdef ARB_LOCK_MUX_TIMEOUT_EN
            cnt_q      <= {CNT_W{1'b0}};
            lock_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            lock_oh_q <= lock_oh_d;
            m_src_q   <= m_src_d;
`ifdef ARB_LOCK_MUX_TIMEOUT_EN
            cnt_q      <= cnt_d;
            lock_err_q <= lock_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_arb_burst_lock_mux.sv
// Self-checking bench for arb_burst_lock_mux (default build): directed scenarios plus
// randomized traffic checked against a source-index reference model.
module tb_arb_burst_lock_mux;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rstn;
    logic [N-1:0]   s_valid;
    logic [N-1:0]   s_last;
    logic [N*W-1:0] s_data;
    logic [N-1:0]   s_ready;
    logic [N-1:0]   arb_req;
    logic           arb_en;
    logic [N-1:0]   arb_grant;
    logic           m_valid;
    logic           m_last;
    logic [W-1:0]   m_data;
    logic           m_ready;
    logic [1:0]     m_src;
    logic           busy;
    logic           lock_err;

    int checks = 0;
    int errors = 0;
    int mdl_lock = -1;   // locked source index, -1 when idle
    int mdl_src  = 0;    // last locked source
    logic [W-1:0] acc_q[$];

    arb_burst_lock_mux #(.REQ_NUM(N), .DATA_W(W), .TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_ready(s_ready),
        .arb_req(arb_req), .arb_en(arb_en), .arb_grant(arb_grant),
        .m_valid(m_valid), .m_last(m_last), .m_data(m_data), .m_ready(m_ready),
        .m_src(m_src), .busy(busy), .lock_err(lock_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int low_idx(input logic [N-1:0] g);
        logic [N-1:0] p;
        int idx;
        p   = g & (~g + 4'd1);
        idx = 0;
        for (int i = 0; i < N; i++) if (p[i]) idx = i;
        return idx;
    endfunction

    // One clock cycle: drive, check against the model mid-cycle, advance the model.
    task automatic cyc(input logic [N-1:0] sv, input logic [N-1:0] sl,
                       input logic [N-1:0] gr, input logic mr);
        logic [W-1:0] word;
        s_valid = sv; s_last = sl; arb_grant = gr; m_ready = mr;
        #4;
        if (mdl_lock < 0) begin
            chk("arb_req_idle", 64'(arb_req), 64'(sv));
            chk("arb_en_idle", 64'(arb_en), 64'(sv != 4'd0 && gr != 4'd0));
            chk("s_ready_idle", 64'(s_ready), 64'd0);
            chk("m_valid_idle", 64'(m_valid), 64'd0);
            chk("busy_idle", 64'(busy), 64'd0);
        end else begin
            word = s_data[mdl_lock*W +: W];
            chk("arb_req_lock", 64'(arb_req), 64'd0);
            chk("arb_en_lock", 64'(arb_en), 64'd0);
            chk("busy_lock", 64'(busy), 64'd1);
            chk("m_valid_lock", 64'(m_valid), 64'(sv[mdl_lock]));
            chk("m_last_lock", 64'(m_last), 64'(sl[mdl_lock]));
            chk("m_data_lock", 64'(m_data), 64'(word));
            chk("s_ready_lock", 64'(s_ready), mr ? (64'd1 << mdl_lock) : 64'd0);
        end
        chk("m_src", 64'(m_src), 64'(mdl_src));
        chk("lock_err", 64'(lock_err), 64'd0);
        if (m_valid && m_ready) acc_q.push_back(m_data);
        if (mdl_lock < 0) begin
            if (sv != 4'd0 && gr != 4'd0) begin
                mdl_lock = low_idx(gr);
                mdl_src  = mdl_lock;
            end
        end else if (sv[mdl_lock] && mr && sl[mdl_lock]) begin
            mdl_lock = -1;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check outputs at once, release after the next edge.
    task automatic pulse_reset(input logic [N-1:0] sv, input logic [N-1:0] gr);
        s_valid = sv; s_last = sv; arb_grant = gr; m_ready = 1'b1;
        rstn = 1'b0;
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_arb_en", 64'(arb_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_src", 64'(m_src), 64'd0);
        chk("rst_lock_err", 64'(lock_err), 64'd0);
        chk("rst_arb_req", 64'(arb_req), 64'(sv));
        mdl_lock = -1;
        mdl_src  = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        logic [4:0] pat;
        int k;
        rstn = 1'b0; s_valid = '0; s_last = '0; s_data = '0; arb_grant = '0; m_ready = 1'b0;
        @(posedge clk);
        #1;
        pulse_reset(4'b0000, 4'b0000);

        // Lock source 0 while source 2 also requests
        s_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        cyc(4'b0101, 4'b0000, 4'b0001, 1'b1);
        chk("req035_busy", 64'(busy), 64'd1);
        chk("req035_src", 64'(m_src), 64'd0);
        chk("req035_rdy2", 64'(s_ready[2]), 64'd0);
        cyc(4'b0101, 4'b0000, 4'b0000, 1'b1);
        cyc(4'b0101, 4'b0001, 4'b0000, 1'b1);

        // Four-beat burst from source 1 with a back-pressure bubble
        acc_q.delete();
        pat = 5'b11101;
        k = 0;
        s_data = '0;
        s_data[1*W +: W] = 32'hB000_0000;
        cyc(4'b0010, 4'b0000, 4'b0010, 1'b1);
        for (int i = 0; i < 5; i++) begin
            s_data[1*W +: W] = 32'hB000_0000 + 32'(k);
            cyc(4'b0010, (k == 3) ? 4'b0010 : 4'b0000, 4'b0000, pat[i]);
            if (pat[i]) k++;
        end
        chk("req036_nbeats", 64'(acc_q.size()), 64'd4);
        for (int j = 0; j < 4 && j < acc_q.size(); j++)
            chk("req036_order", 64'(acc_q[j]), 64'(32'hB000_0000 + 32'(j)));
        chk("req036_idle", 64'(busy), 64'd0);

        // Non-one-hot grant locks its lowest bit
        s_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        cyc(4'b0110, 4'b0000, 4'b0110, 1'b1);
        chk("req037_src", 64'(m_src), 64'd1);
        cyc(4'b0110, 4'b0010, 4'b0000, 1'b1);

        // No grant: stay idle
        for (int i = 0; i < 5; i++) cyc(4'b1000, 4'b0000, 4'b0000, 1'b1);
        chk("req038_busy", 64'(busy), 64'd0);

        // Grant outside s_valid still locks; locked source idles mid-burst
        cyc(4'b0001, 4'b0000, 4'b1100, 1'b1);
        chk("grant_outside_src", 64'(m_src), 64'd2);
        for (int i = 0; i < 3; i++) cyc(4'b0001, 4'b0000, 4'b0001, 1'b1);
        cyc(4'b0100, 4'b0100, 4'b0000, 1'b1);

        // Reset in the middle of a burst, then a fresh arbitration
        cyc(4'b0100, 4'b0000, 4'b0100, 1'b1);
        cyc(4'b0100, 4'b0000, 4'b0000, 1'b1);
        pulse_reset(4'b0100, 4'b0100);
        cyc(4'b0100, 4'b0000, 4'b0100, 1'b1);
        chk("req039_relock", 64'(busy), 64'd1);
        cyc(4'b0100, 4'b0100, 4'b0000, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            s_data = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 63) == 0)
                pulse_reset(4'($urandom), 4'($urandom));
            else
                cyc(4'($urandom), 4'($urandom) & 4'($urandom),
                    ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
